input_debouncer: RTL and testbench

- Upstream conditioning stage for edge_detector: takes a raw, asynchronous, possibly bouncing level input (button, external strobe) and produces a clean, clock-synchronous level for edge_detector's a_i.
- Synchronizes the input through a flop chain, then accepts a level change only after it has held for a programmable number of cycles.
- Also emits a one-cycle change strobe and a busy flag for status and debug.

---
 rtl/input_debouncer.sv | 128 ++++++++++++
 tb/tb_input_debouncer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Raw-level synchronizer and debouncer feeding edge_detector's a_i.
// Optional GLITCH_COUNT_EN adds a saturating rejected-glitch counter on glitch_cnt_o.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_i,
    output logic       db_o,
    output logic       changed_o,
`ifdef GLITCH_COUNT_EN
    output logic [7:0] glitch_cnt_o,
`endif
    output logic       busy_o
);

    // state      | meaning
    // IDLE_LOW   | db_o=0, synchronized input agrees
    // WAIT_HIGH  | db_o=0, qualifying a rise
    // IDLE_HIGH  | db_o=1, synchronized input agrees
    // WAIT_LOW   | db_o=1, qualifying a fall
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_d, changed_d;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            db_o      <= 1'b0;
            changed_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_o      <= db_d;
            changed_o <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        db_d      = db_o;
        changed_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_HIGH;
                    db_d      = 1'b1;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    db_d      = 1'b0;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

`ifdef GLITCH_COUNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    // An abort is the synchronized level returning to db_o while qualifying.
    assign abort = ((state_q == WAIT_HIGH) && !s) || ((state_q == WAIT_LOW) && s);

    always_ff @(posedge clk) begin
        if (reset)                          glitch_q <= '0;
        else if (abort && glitch_q != 8'hFF) glitch_q <= glitch_q + 8'd1;
    end

    assign glitch_cnt_o = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a run-length model of the debounce rules
// is compared every cycle, plus hand-computed literal checkpoints.
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_i;
    logic       db_o, changed_o, busy_o;
`ifdef GLITCH_COUNT_EN
    logic [7:0] glitch_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_i        (raw_i),
        .db_o         (db_o),
        .changed_o    (changed_o),
`ifdef GLITCH_COUNT_EN
        .glitch_cnt_o (glitch_cnt_o),
`endif
        .busy_o       (busy_o)
    );

    // Model: raw_i reaches the qualifier SYNC edges after it is sampled; a level
    // differing from db for DEB consecutive edges is accepted, an earlier return aborts.
    typedef struct {
        logic [3:0] hist;
        int         run;
        bit         db;
        bit         chg;
        int         glitch;
    } model_t;

    model_t m;
    bit     m_valid = 1'b0;

    function automatic model_t model_step(model_t cur, bit raw, bit rst);
        model_t n;
        bit     s_seen;
        n = cur;
        if (rst) begin
            n.hist   = '0;
            n.run    = 0;
            n.db     = 1'b0;
            n.chg    = 1'b0;
            n.glitch = 0;
            return n;
        end
        s_seen = cur.hist[SYNC-1];
        n.hist = {cur.hist[2:0], raw};
        n.chg  = 1'b0;
        if (s_seen != cur.db) begin
            n.run = cur.run + 1;
            if (n.run == DEB) begin
                n.db  = s_seen;
                n.chg = 1'b1;
                n.run = 0;
            end
        end else if (cur.run > 0) begin
            n.run = 0;
            if (cur.glitch < 255) n.glitch = cur.glitch + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m       <= model_step(m, raw_i, reset);
        m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_db",      32'(db_o),      32'(m.db));
            check("model_changed", 32'(changed_o), 32'(m.chg));
            check("model_busy",    32'(busy_o),    32'(m.run > 0));
`ifdef GLITCH_COUNT_EN
            check("model_glitch",  32'(glitch_cnt_o), 32'(m.glitch));
`endif
        end
    end

    always @(posedge clk) begin
        #1;
        if (changed_o === 1'b1) pulses <= pulses + 1;
    end

    task automatic hold(input bit v, input int n);
        raw_i = v;
        repeat (n) @(negedge clk);
    endtask

    int p0;

    initial begin
        reset = 1'b1;
        raw_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_db",   32'(db_o),      32'd0);
        check("reset_chg",  32'(changed_o), 32'd0);
        check("reset_busy", 32'(busy_o),    32'd0);
        reset = 1'b0;
        hold(1'b0, 3);
        check("idle_db",   32'(db_o),   32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);

        // clean rise: edge k is the first edge after raw_i goes high
        raw_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 2) check("rise_busy_k1", 32'(busy_o), 32'd0);
            if (i == 3) check("rise_busy_k2", 32'(busy_o), 32'd1);
            if (i == 5) begin
                check("rise_db_k4",   32'(db_o),   32'd0);
                check("rise_busy_k4", 32'(busy_o), 32'd1);
            end
            if (i == 6) begin
                check("rise_db_k5",   32'(db_o),      32'd1);
                check("rise_chg_k5",  32'(changed_o), 32'd1);
                check("rise_busy_k5", 32'(busy_o),    32'd0);
            end
            if (i == 7) check("rise_chg_k6", 32'(changed_o), 32'd0);
        end
        hold(1'b1, 3);

        // clean fall
        raw_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 5) check("fall_db_k4",  32'(db_o),      32'd1);
            if (i == 6) begin
                check("fall_db_k5",  32'(db_o),      32'd0);
                check("fall_chg_k5", 32'(changed_o), 32'd1);
            end
        end
        hold(1'b0, 3);

        // bounce on the way up
        p0 = pulses;
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 5);
        check("bounce_db_early", 32'(db_o), 32'd0);
        hold(1'b1, 1);
        check("bounce_db", 32'(db_o), 32'd1);
        hold(1'b1, 4);
        check("bounce_pulses", 32'(pulses - p0), 32'd1);
`ifdef GLITCH_COUNT_EN
        check("bounce_glitch", 32'(glitch_cnt_o), 32'd2);
`endif

        // low pulse one cycle short of acceptance
        p0 = pulses;
        hold(1'b0, 3);
        hold(1'b1, 10);
        check("short_low_db",     32'(db_o),         32'd1);
        check("short_low_pulses", 32'(pulses - p0), 32'd0);

        // reset mid-qualification
        reset = 1'b1;
        hold(1'b0, 2);
        reset = 1'b0;
        hold(1'b0, 4);
        p0 = pulses;
        hold(1'b1, 3);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_db",   32'(db_o),   32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_db_j4", 32'(db_o), 32'd0);
        @(negedge clk);
        check("midrst_db_j5",  32'(db_o),      32'd1);
        check("midrst_chg_j5", 32'(changed_o), 32'd1);
        check("midrst_pulses", 32'(pulses - p0), 32'd1);
        hold(1'b1, 4);

        // 300 single-cycle low glitches while high
        p0 = pulses;
        for (int i = 0; i < 300; i++) begin
            hold(1'b0, 1);
            hold(1'b1, 1);
        end
        hold(1'b1, 6);
        check("sat_db",     32'(db_o),         32'd1);
        check("sat_pulses", 32'(pulses - p0), 32'd0);
`ifdef GLITCH_COUNT_EN
        check("sat_glitch", 32'(glitch_cnt_o), 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
